config_word_packer: RTL
=======================

Name: config_word_packer

Overview:
- Byte-to-word assembler that sits directly upstream of the configuration FSM.
- Takes the byte stream from the UART/parallel configuration receiver and packs it MSB-first into 32-bit words. Each completed word is presented on WriteData with a one-cycle WriteStrobe.
- Generates ComActive: high for the duration of a configuration session, low after an idle timeout. It drives the FSM's FSM_Reset input, so every new session starts with a fresh ComActive rising edge.

Parameters:
- TimeoutCycles, 65535: idle cycles without ByteValid before the session ends. Minimum legal value 2.
- TimeoutWidth, 16: width of the idle counter. Requires TimeoutCycles <= 2^TimeoutWidth - 1.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- resetn  input  1  reset, synchronous active-low.
- ByteData  input  8  received byte.
- ByteValid  input  1  ByteData valid this cycle; one byte per asserted cycle, back-to-back allowed.
- WriteData  output  32  assembled word; holds its value between strobes.
- WriteStrobe  output  1  one-cycle pulse, WriteData valid.
- ComActive  output  1  configuration session active (to FSM_Reset).
- PartialError  output  1  sticky: a session ended with 1-3 bytes pending.

Behaviour:
- Reset: on resetn==0 at a CLK edge, the following are cleared:
  - WriteData=0, WriteStrobe=0, ComActive=0, PartialError=0.
  - shift register=0, byte index=0, idle counter=0, state=IDLE.
- State machine:
  - IDLE: ComActive=0. On ByteValid:
    - state<=ACTIVE, ComActive<=1 (rises the cycle after the first byte);
    - PartialError<=0, shift<={24'b0,ByteData}, index<=1, idle counter<=0.
  - ACTIVE: ComActive=1. On ByteValid:
    - shift<={shift[23:0],ByteData}, idle counter<=0, index<=index+1 (mod 4).
    - When index==3 with ByteValid: WriteData<={shift[23:0],ByteData}, WriteStrobe<=1, index<=0.
    - Byte 0 lands in WriteData[31:24].
  - ACTIVE without ByteValid: idle counter increments. When it reaches TimeoutCycles-1:
    - state<=IDLE, ComActive<=0, idle counter<=0;
    - if index!=0, PartialError<=1 and index<=0 (partial word discarded, no strobe).
- WriteStrobe timing:
  - Registered; high exactly one cycle, the cycle after the 4th byte's ByteValid; low otherwise.
  - Back-to-back bytes give strobes every 4 cycles.
- Latency: the first WriteStrobe of a session comes at least 3 cycles after the ComActive rise, so the downstream FSM always sees its reset edge before data.
- Simultaneous ByteValid and timeout expiry: the byte wins. It is accepted, the counter clears, and the session stays active.
- Timeout exactly at a word boundary (index==0): clean end, PartialError unchanged.
- A new session after a timeout always produces a fresh ComActive rising edge. ComActive is low for at least one cycle between sessions.
- Reset mid-word or mid-session: all state is discarded immediately on the next edge; no strobe is issued for pending bytes.
- Idle counter never wraps; it is held at 0 in IDLE.

Optional Feature:
- Macro: CONFIG_PACKER_WORDCOUNT_EN.
- When defined:
  - Adds output WordCount[15:0] (reset 0).
  - Cleared when a new session starts (IDLE to ACTIVE); incremented with each WriteStrobe.
  - Saturates at 16'hFFFF; holds its value after the session ends until the next session starts.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then bytes FA,B0,FA,B1 back-to-back -> ComActive=1 from the cycle after FA; one WriteStrobe with WriteData=32'hFAB0FAB1 the cycle after B1; PartialError=0.
- 8 bytes 01..08 with 3 idle cycles between each (TimeoutCycles=16) -> strobes carrying 32'h01020304 then 32'h05060708; ComActive stays high; then 16 idle cycles -> ComActive falls, PartialError=0.
- TimeoutCycles=4; send AA,BB then idle -> ComActive falls after idle count reaches 3; PartialError=1; no strobe. Then send 11,22,33,44 -> ComActive rises again, PartialError clears, WriteData=32'h11223344.
- TimeoutCycles=4; ByteValid on the exact cycle the counter hits 3 -> byte accepted, ComActive stays 1, word completes correctly.
- Assert resetn=0 for one cycle after 2 bytes of a word -> all outputs 0. Next 4 bytes C0,C1,C2,C3 -> WriteData=32'hC0C1C2C3 (no leftover bytes).
- With CONFIG_PACKER_WORDCOUNT_EN: 3 words, then timeout, then 1 word -> WordCount reads 3 after the first session and 1 after the second.

Source files
------------

// File: rtl/config_word_packer.sv
// Purpose: packs a configuration byte stream MSB-first into 32-bit words and frames sessions with ComActive.
// Latency: WriteStrobe/WriteData register one cycle after the 4th byte; ComActive rises one cycle after the first byte.
// Backpressure: none; every ByteValid byte is accepted. Optional WordCount output under CONFIG_PACKER_WORDCOUNT_EN.
module config_word_packer #(
    parameter int TimeoutCycles = 65535,  // idle cycles that end a session, at least 2
    parameter int TimeoutWidth  = 16      // must hold TimeoutCycles-1
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic [7:0]  ByteData,
    input  logic        ByteValid,
    output logic [31:0] WriteData,
    output logic        WriteStrobe,
    output logic        ComActive,
    output logic        PartialError
`ifdef CONFIG_PACKER_WORDCOUNT_EN
    ,
    output logic [15:0] WordCount
`endif
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Last idle count value; an idle cycle seen at this value ends the session.
    localparam logic [TimeoutWidth-1:0] IDLE_LAST = TimeoutWidth'(TimeoutCycles - 1);

    logic [0:0]              state_q, state_d;
    logic [23:0]             shift_q, shift_d;   // only the three most recent bytes are ever needed
    logic [1:0]              index_q, index_d;
    logic [TimeoutWidth-1:0] idle_q, idle_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    strobe_q, strobe_d;
    logic                    perr_q, perr_d;
`ifdef CONFIG_PACKER_WORDCOUNT_EN
    logic [15:0]             wcount_q, wcount_d;
`endif

    // Next-state: byte acceptance takes priority over idle timeout expiry.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        index_d  = index_q;
        idle_d   = idle_q;
        wdata_d  = wdata_q;
        strobe_d = 1'b0;
        perr_d   = perr_q;
`ifdef CONFIG_PACKER_WORDCOUNT_EN
        wcount_d = wcount_q;
`endif
        case (state_q)
            ST_IDLE: begin
                idle_d = '0;
                if (ByteValid) begin
                    state_d = ST_ACTIVE;
                    perr_d  = 1'b0;
                    shift_d = {16'b0, ByteData};
                    index_d = 2'd1;
`ifdef CONFIG_PACKER_WORDCOUNT_EN
                    wcount_d = 16'd0;
`endif
                end
            end
            ST_ACTIVE: begin
                if (ByteValid) begin
                    shift_d = {shift_q[15:0], ByteData};
                    idle_d  = '0;
                    index_d = index_q + 2'd1;
                    if (index_q == 2'd3) begin
                        wdata_d  = {shift_q, ByteData};
                        strobe_d = 1'b1;
`ifdef CONFIG_PACKER_WORDCOUNT_EN
                        if (wcount_q != 16'hFFFF) begin
                            wcount_d = wcount_q + 16'd1;
                        end
`endif
                    end
                end else if (idle_q == IDLE_LAST) begin
                    // Session over; any partially assembled word is dropped and flagged.
                    state_d = ST_IDLE;
                    idle_d  = '0;
                    if (index_q != 2'd0) begin
                        perr_d  = 1'b1;
                        index_d = 2'd0;
                    end
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idle_d  = '0;
                index_d = 2'd0;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            index_q  <= '0;
            idle_q   <= '0;
            wdata_q  <= '0;
            strobe_q <= 1'b0;
            perr_q   <= 1'b0;
`ifdef CONFIG_PACKER_WORDCOUNT_EN
            wcount_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            index_q  <= index_d;
            idle_q   <= idle_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
            perr_q   <= perr_d;
`ifdef CONFIG_PACKER_WORDCOUNT_EN
            wcount_q <= wcount_d;
`endif
        end
    end

    assign WriteData    = wdata_q;
    assign WriteStrobe  = strobe_q;
    assign ComActive    = (state_q == ST_ACTIVE);
    assign PartialError = perr_q;
`ifdef CONFIG_PACKER_WORDCOUNT_EN
    assign WordCount    = wcount_q;
`endif

endmodule
